// File: rtl/vfpu_lzc_pipe.sv
// Multi-lane pipelined leading/trailing-one detector with valid/ready backpressure.
// Stage 0 does a coarse byte-group search and later stages refine the index within the chosen group.
module vfpu_lzc_pipe #(
  parameter  int WIDTH     = 48,
  parameter  int NUM_LANES = 4,
  parameter  int LATENCY   = 2,
  parameter  int TAG_WIDTH = 4,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [NUM_LANES*WIDTH-1:0] in_data_i,
  input  logic                       in_mode_i,
  input  logic [TAG_WIDTH-1:0]       in_tag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [NUM_LANES*IDX_W-1:0] out_index_o,
  output logic [NUM_LANES-1:0]       out_no_ones_o,
  output logic                       out_all_zero_o,
  output logic [TAG_WIDTH-1:0]       out_tag_o
);

  localparam int GRP_W   = (WIDTH < 8) ? WIDTH : 8;
  localparam int NUM_GRP = (WIDTH + GRP_W - 1) / GRP_W;
  localparam int GIDX_W  = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int FIDX_W  = $clog2(GRP_W);
  localparam int PAD_W   = NUM_GRP * GRP_W;
  // With a single stage the refinement runs in the same cycle as the coarse search.
  localparam int FIRST_F = (LATENCY > 1) ? 1 : 0;

  logic [LATENCY-1:0]           valid_r;
  logic [LATENCY-1:0]           ready_s;
  logic                         src_valid_s;

  logic [GIDX_W-1:0]            cs_grp_s   [NUM_LANES];
  logic [GRP_W-1:0]             cs_slice_s [NUM_LANES];
  logic [NUM_LANES-1:0]         cs_none_s;

  logic [GIDX_W-1:0]            c_grp_r    [NUM_LANES];
  logic [GRP_W-1:0]             c_slice_r  [NUM_LANES];
  logic [NUM_LANES-1:0]         c_none_r;
  logic                         c_mode_r;
  logic [TAG_WIDTH-1:0]         c_tag_r;

  logic [GIDX_W-1:0]            rf_grp_s   [NUM_LANES];
  logic [GRP_W-1:0]             rf_slice_s [NUM_LANES];
  logic [NUM_LANES-1:0]         rf_none_s;
  logic                         rf_mode_s;
  logic [TAG_WIDTH-1:0]         rf_tag_s;
  logic [NUM_LANES*IDX_W-1:0]   rf_index_s;

  logic [NUM_LANES*IDX_W-1:0]   f_index_r    [FIRST_F:LATENCY-1];
  logic [NUM_LANES-1:0]         f_no_ones_r  [FIRST_F:LATENCY-1];
  logic                         f_all_zero_r [FIRST_F:LATENCY-1];
  logic [TAG_WIDTH-1:0]         f_tag_r      [FIRST_F:LATENCY-1];

  // Returns {none, group, group_bits}: the highest (mode 0) or lowest (mode 1) non-empty group.
  function automatic logic [GIDX_W+GRP_W:0] coarse_pick(input logic [WIDTH-1:0] v,
                                                        input logic mode);
    logic [PAD_W-1:0]  pad;
    logic [GIDX_W-1:0] grp;
    logic              found;
    logic              any;
    pad   = PAD_W'(v);
    grp   = {GIDX_W{1'b0}};
    found = 1'b0;
    for (int g = 0; g < NUM_GRP; g++) begin
      any   = |pad[g*GRP_W +: GRP_W];
      grp   = (any && (!mode || !found)) ? GIDX_W'(g) : grp;
      found = found | any;
    end
    return {~found, grp, pad[grp*GRP_W +: GRP_W]};
  endfunction

  // Absolute bit position of the selected one; an empty group yields index 0.
  function automatic logic [IDX_W-1:0] refine(input logic [GIDX_W-1:0] grp,
                                              input logic [GRP_W-1:0]  bits,
                                              input logic              mode);
    logic [FIDX_W-1:0] fine;
    logic              found;
    fine  = {FIDX_W{1'b0}};
    found = 1'b0;
    for (int i = 0; i < GRP_W; i++) begin
      fine  = (bits[i] && (!mode || !found)) ? FIDX_W'(i) : fine;
      found = found | bits[i];
    end
    return IDX_W'(int'(grp) * GRP_W + int'(fine));
  endfunction

  // Per-stage ready: a stage can accept if it or any stage downstream has a hole.
  always_comb begin
    ready_s = {LATENCY{1'b0}};
    for (int k = 0; k < LATENCY; k++) begin
      ready_s[k] = out_ready_i;
      for (int j = k; j < LATENCY; j++) begin
        ready_s[k] = ready_s[k] | ~valid_r[j];
      end
    end
  end

  assign in_ready_o  = ready_s[0];
  assign src_valid_s = (LATENCY > 1) ? valid_r[0] : in_valid_i;

  // Coarse group search on the incoming data.
  always_comb begin
    cs_none_s = {NUM_LANES{1'b0}};
    for (int l = 0; l < NUM_LANES; l++) begin
      {cs_none_s[l], cs_grp_s[l], cs_slice_s[l]} =
        coarse_pick(in_data_i[l*WIDTH +: WIDTH], in_mode_i);
    end
  end

  // Refinement source: registered coarse stage, or the live coarse result for a one-stage pipe.
  always_comb begin
    rf_none_s  = (LATENCY > 1) ? c_none_r : cs_none_s;
    rf_mode_s  = (LATENCY > 1) ? c_mode_r : in_mode_i;
    rf_tag_s   = (LATENCY > 1) ? c_tag_r  : in_tag_i;
    rf_index_s = {(NUM_LANES*IDX_W){1'b0}};
    for (int l = 0; l < NUM_LANES; l++) begin
      rf_grp_s[l]   = (LATENCY > 1) ? c_grp_r[l]   : cs_grp_s[l];
      rf_slice_s[l] = (LATENCY > 1) ? c_slice_r[l] : cs_slice_s[l];
      rf_index_s[l*IDX_W +: IDX_W] = refine(rf_grp_s[l], rf_slice_s[l], rf_mode_s);
    end
  end

  // Stage valid bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= {LATENCY{1'b0}};
    end else begin
      if (ready_s[0]) begin
        valid_r[0] <= in_valid_i;
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (ready_s[k]) begin
          valid_r[k] <= valid_r[k-1];
        end
      end
    end
  end

  // Coarse-stage payload registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_none_r <= {NUM_LANES{1'b0}};
      c_mode_r <= 1'b0;
      c_tag_r  <= {TAG_WIDTH{1'b0}};
      for (int l = 0; l < NUM_LANES; l++) begin
        c_grp_r[l]   <= {GIDX_W{1'b0}};
        c_slice_r[l] <= {GRP_W{1'b0}};
      end
    end else if (ready_s[0] && in_valid_i) begin
      c_none_r <= cs_none_s;
      c_mode_r <= in_mode_i;
      c_tag_r  <= in_tag_i;
      for (int l = 0; l < NUM_LANES; l++) begin
        c_grp_r[l]   <= cs_grp_s[l];
        c_slice_r[l] <= cs_slice_s[l];
      end
    end
  end

  // Result stages; the last one drives the outputs directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = FIRST_F; k < LATENCY; k++) begin
        f_index_r[k]    <= {(NUM_LANES*IDX_W){1'b0}};
        f_no_ones_r[k]  <= {NUM_LANES{1'b0}};
        f_all_zero_r[k] <= 1'b0;
        f_tag_r[k]      <= {TAG_WIDTH{1'b0}};
      end
    end else begin
      if (ready_s[FIRST_F] && src_valid_s) begin
        f_index_r[FIRST_F]    <= rf_index_s;
        f_no_ones_r[FIRST_F]  <= rf_none_s;
        f_all_zero_r[FIRST_F] <= &rf_none_s;
        f_tag_r[FIRST_F]      <= rf_tag_s;
      end
      for (int k = FIRST_F + 1; k < LATENCY; k++) begin
        if (ready_s[k] && valid_r[k-1]) begin
          f_index_r[k]    <= f_index_r[k-1];
          f_no_ones_r[k]  <= f_no_ones_r[k-1];
          f_all_zero_r[k] <= f_all_zero_r[k-1];
          f_tag_r[k]      <= f_tag_r[k-1];
        end
      end
    end
  end

  assign out_valid_o    = valid_r[LATENCY-1];
  assign out_index_o    = f_index_r[LATENCY-1];
  assign out_no_ones_o  = f_no_ones_r[LATENCY-1];
  assign out_all_zero_o = f_all_zero_r[LATENCY-1];
  assign out_tag_o      = f_tag_r[LATENCY-1];

endmodule

// File: tb/tb_vfpu_lzc_pipe.sv
// Scoreboard bench for vfpu_lzc_pipe: driver pushes reference results, a negedge monitor pops and compares.
module tb_vfpu_lzc_pipe;
  localparam int W   = 48;
  localparam int NL  = 2;
  localparam int LAT = 2;
  localparam int TW  = 4;
  localparam int IW  = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [NL*W-1:0]  in_data;
  logic             in_mode;
  logic [TW-1:0]    in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [NL*IW-1:0] out_index;
  logic [NL-1:0]    out_no_ones;
  logic             out_all_zero;
  logic [TW-1:0]    out_tag;

  always #5 clk = ~clk;

  vfpu_lzc_pipe #(.WIDTH(W), .NUM_LANES(NL), .LATENCY(LAT), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_mode_i(in_mode), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_index_o(out_index), .out_no_ones_o(out_no_ones),
    .out_all_zero_o(out_all_zero), .out_tag_o(out_tag)
  );

  typedef struct {
    logic [NL*IW-1:0] index;
    logic [NL-1:0]    no_ones;
    logic             all_zero;
    logic [TW-1:0]    tag;
    int               acc;
    bit               chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors  = 0;
  int   checks  = 0;
  int   cycle   = 0;
  int   emitted = 0;
  bit   stream_on;
  logic        stall_prev = 1'b0;
  logic [63:0] snap;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: position of highest / lowest set bit by plain shifting.
  function automatic exp_t model(input logic [NL*W-1:0] d, input logic m, input logic [TW-1:0] t);
    exp_t e;
    e.index   = '0;
    e.no_ones = '0;
    e.tag     = t;
    e.acc     = 0;
    e.chk_lat = 1'b0;
    for (int l = 0; l < NL; l++) begin
      longint unsigned v;
      int p;
      v = 64'(d[l*W +: W]);
      p = 0;
      if (v == 64'd0) e.no_ones[l] = 1'b1;
      else if (!m) begin
        while ((v >> (p + 1)) != 64'd0) p++;
      end else begin
        while (((v >> p) & 64'd1) == 64'd0) p++;
      end
      e.index[l*IW +: IW] = p[IW-1:0];
    end
    e.all_zero = &e.no_ones;
    return e;
  endfunction

  task automatic push(input logic [NL*W-1:0] d, input logic m, input logic [TW-1:0] t, input bit lat);
    exp_t e;
    e = model(d, m, t);
    e.acc = cycle;
    e.chk_lat = lat;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic m,
                       input logic [TW-1:0] t, input bit lat);
    int waitc;
    waitc = 0;
    in_valid = 1'b1;
    in_data  = {d1, d0};
    in_mode  = m;
    in_tag   = t;
    @(negedge clk);
    while (!in_ready && waitc < 300) begin
      waitc++;
      @(negedge clk);
    end
    check("issue_accept", in_ready, 1'b1);
    if (in_ready) push({d1, d0}, m, t, lat);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_lane();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = {W{1'b0}};
      1:       v = {{(W-1){1'b0}}, 1'b1} << $urandom_range(0, W-1);
      default: v = W'({$urandom(), $urandom()});
    endcase
    return v;
  endfunction

  // Monitor: output stability under stall and in-order scoreboard compare on each transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_data", {out_index, out_no_ones, out_all_zero, out_tag}, snap);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out: got tag 0x%0h expected no output (cycle %0d)", out_tag, cycle);
          end else begin
            mon_e = sb.pop_front();
            check("index", out_index, mon_e.index);
            check("no_ones", out_no_ones, mon_e.no_ones);
            check("all_zero", out_all_zero, mon_e.all_zero);
            check("tag", out_tag, mon_e.tag);
            if (mon_e.chk_lat) check("latency", cycle - mon_e.acc, LAT);
            emitted++;
          end
        end
        stall_prev = out_valid && !out_ready;
        snap = {out_index, out_no_ones, out_all_zero, out_tag};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_index", out_index, '0);
    check("rst_no_ones", out_no_ones, '0);
    check("rst_all_zero", out_all_zero, 1'b0);
    check("rst_tag", out_tag, '0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed searches, unstalled, latency checked.
    issue(48'h0F00F00FF0F0, 48'h8000F00FF0F0, 1'b0, 4'h3, 1'b1);
    issue(48'h0F00F00FF0F0, 48'h8000F00FF0F0, 1'b1, 4'h5, 1'b1);
    issue(48'h000000000001, 48'h000000000000, 1'b0, 4'h6, 1'b1);
    issue(48'h000000000000, 48'h000000000000, 1'b0, 4'h7, 1'b1);
    drain();

    // Backpressure: fill with tags 1,2 while tag 3 waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = {48'h000000100000, 48'h000000000300};
    in_tag    = 4'h1;
    @(negedge clk);
    check("bp_ready_t1", in_ready, 1'b1);
    push(in_data, in_mode, in_tag, 1'b0);
    @(posedge clk);
    #1 in_tag = 4'h2; in_mode = 1'b1; in_data = {48'h800000000000, 48'h0000000000C0};
    @(negedge clk);
    check("bp_ready_t2", in_ready, 1'b1);
    push(in_data, in_mode, in_tag, 1'b0);
    @(posedge clk);
    #1 in_tag = 4'h3; in_mode = 1'b0; in_data = {48'h000000000000, 48'h7FFFFFFFFFFF};
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_t3", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_tag", out_tag, 4'h1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_full_accept", in_ready, 1'b1);
    check("bp_emit_t1", out_tag, 4'h1);
    push(in_data, in_mode, in_tag, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_emit_t2_valid", out_valid, 1'b1);
    check("bp_emit_t2", out_tag, 4'h2);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_emit_t3_valid", out_valid, 1'b1);
    check("bp_emit_t3", out_tag, 4'h3);
    @(posedge clk);
    #1;
    drain();

    // Random streaming with random gaps and random backpressure.
    stream_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 50; n++) begin
          while ($urandom_range(0, 1) == 0) begin
            @(posedge clk);
            #1;
          end
          issue(rnd_lane(), rnd_lane(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
        end
        stream_on = 1'b0;
      end
      begin
        while (stream_on) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two transactions in flight; they must never appear.
    out_ready = 1'b0;
    issue(48'h123456789ABC, 48'h000000000010, 1'b0, 4'hA, 1'b0);
    issue(48'h000000000000, 48'hFFFF00000000, 1'b1, 4'hB, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_index", out_index, '0);
    check("mrst_no_ones", out_no_ones, '0);
    check("mrst_all_zero", out_all_zero, 1'b0);
    check("mrst_tag", out_tag, '0);
    check("mrst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    issue(48'h000000000800, 48'h000000000000, 1'b1, 4'hC, 1'b1);
    drain();
    repeat (4) @(posedge clk);

    check("emitted_count", emitted, 58);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
